axi_config_arb: RTL and testbench



---
 rtl/axi_config_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/axi_config_arb.sv | 218 +++++++++++++++++++++
 tb/tb_axi_config_arb.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_config_arb_pkg.sv
// Shared types and elaboration helpers for the register-bus arbiter.
//   arb_state_t : arbiter transaction state
//   idx_width() : bits needed to index n ports (never below 1)
//   cnt_width() : bits needed to hold a timeout count (never below 1)
package axi_config_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        RWAIT = 3'd3,
        RESP  = 3'd4
    } arb_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant.
// Searches upward from last+1 (modulo NUM_PORTS) and grants the first
// requesting port.
//   req         in  NUM_PORTS : request vector
//   last        in  IDX_W     : index of the previously granted port
//   grant_c     out NUM_PORTS : one-hot grant, zero when nothing requests
//   grant_idx_c out IDX_W     : index of the granted port (0 when none)
module rr_arbiter
    import axi_config_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    localparam int unsigned IDX_W    = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic [NUM_PORTS-1:0] grant_c,
    output logic [IDX_W-1:0]     grant_idx_c
);

    // Rotating priority search; offset NUM_PORTS wraps back to last itself.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        idx         = 0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            idx = (32'(last) + i) % NUM_PORTS;
            if (!found && req[IDX_W'(idx)]) begin
                found                  = 1'b1;
                grant_c[IDX_W'(idx)]   = 1'b1;
                grant_idx_c            = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/axi_config_arb.sv
// Round-robin arbiter sharing one register-bus target between NUM_PORTS
// requesters. One transaction in flight; reads are protected by a timeout.
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid/req_ready      : per-port request handshake (ready one-hot, IDLE only)
//   req_we/addr/wdata/wstrb  : packed per-port request fields
//   rsp_valid                : one-hot, one-cycle completion pulse
//   rsp_rdata/rsp_err        : shared response payload, valid with rsp_valid
//   rd/raddr/rdata/rvalid    : target read channel
//   wr/waddr/wdata/wstrb     : target write channel
module axi_config_arb
    import axi_config_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS-1:0]            req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_PORTS*STRB_WIDTH-1:0] req_wstrb,

    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,

    output logic                            rd,
    output logic [ADDR_WIDTH-1:0]           raddr,
    input  logic [DATA_WIDTH-1:0]           rdata,
    input  logic                            rvalid,
    output logic                            wr,
    output logic [ADDR_WIDTH-1:0]           waddr,
    output logic [DATA_WIDTH-1:0]           wdata,
    output logic [STRB_WIDTH-1:0]           wstrb
);

    localparam int unsigned IDX_W = idx_width(NUM_PORTS);
    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    arb_state_t             state, state_d;
    logic [IDX_W-1:0]       last, last_d;
    logic [CNT_W-1:0]       cnt, cnt_d, cnt_inc;
    logic                   timeout_hit;

    logic                   rd_d, wr_d;
    logic [ADDR_WIDTH-1:0]  raddr_d, waddr_d;
    logic [DATA_WIDTH-1:0]  wdata_d;
    logic [STRB_WIDTH-1:0]  wstrb_d;
    logic [NUM_PORTS-1:0]   rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_d;
    logic                   rsp_err_d;

    logic [NUM_PORTS-1:0]   grant;
    logic [IDX_W-1:0]       grant_idx;
    logic [NUM_PORTS-1:0]   resp_onehot;

    logic [ADDR_WIDTH-1:0]  port_addr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  port_wdata [NUM_PORTS];
    logic [STRB_WIDTH-1:0]  port_wstrb [NUM_PORTS];
    logic                   sel_we;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic [STRB_WIDTH-1:0]  sel_wstrb;

    // Split the packed request buses into per-port fields.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign port_addr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign port_wdata[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign port_wstrb[gi] = req_wstrb[gi*STRB_WIDTH +: STRB_WIDTH];
    end

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arbiter (
        .req         (req_valid),
        .last        (last),
        .grant_c     (grant),
        .grant_idx_c (grant_idx)
    );

    // Fields of the port that wins arbitration this cycle.
    always_comb begin
        sel_we    = req_we[grant_idx];
        sel_addr  = port_addr[grant_idx];
        sel_wdata = port_wdata[grant_idx];
        sel_wstrb = port_wstrb[grant_idx];
    end

    // Accept is a combinational handshake, only while idle.
    assign req_ready = (state == IDLE) ? grant : '0;

    // Completion is routed back to the port granted for this transaction.
    always_comb begin
        resp_onehot       = '0;
        resp_onehot[last] = 1'b1;
    end

    // cnt holds cycles already waited minus one, so the compare fires in
    // the TIMEOUT-th cycle after the rd strobe.
    assign cnt_inc     = cnt + CNT_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state;
        last_d      = last;
        cnt_d       = cnt;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        raddr_d     = raddr;
        waddr_d     = waddr;
        wdata_d     = wdata;
        wstrb_d     = wstrb;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;

        case (state)
            IDLE: begin
                if (|req_valid) begin
                    last_d = grant_idx;
                    if (sel_we) begin
                        state_d = WRITE;
                        wr_d    = 1'b1;
                        waddr_d = sel_addr;
                        wdata_d = sel_wdata;
                        wstrb_d = sel_wstrb;
                    end else begin
                        state_d = READ;
                        rd_d    = 1'b1;
                        raddr_d = sel_addr;
                    end
                end
            end

            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = resp_onehot;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end

            READ: begin
                cnt_d = '0;
                if (rvalid) begin
                    state_d     = RESP;
                    rsp_valid_d = resp_onehot;
                    rsp_rdata_d = rdata;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = RWAIT;
                end
            end

            RWAIT: begin
                cnt_d = cnt_inc;
                // Data arriving on the timeout cycle still wins.
                if (rvalid) begin
                    state_d     = RESP;
                    rsp_valid_d = resp_onehot;
                    rsp_rdata_d = rdata;
                    rsp_err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = RESP;
                    rsp_valid_d = resp_onehot;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= IDX_W'(NUM_PORTS - 1);
            cnt       <= '0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            raddr     <= '0;
            waddr     <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            last      <= last_d;
            cnt       <= cnt_d;
            rd        <= rd_d;
            wr        <= wr_d;
            raddr     <= raddr_d;
            waddr     <= waddr_d;
            wdata     <= wdata_d;
            wstrb     <= wstrb_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_axi_config_arb.sv
// Scoreboard bench for axi_config_arb (2 ports, 32-bit, TIMEOUT = 4).
// Stimulus pushes expected target strobes and responses, tagged with the
// cycle they must appear in; a negedge monitor pops and compares them.
module tb_axi_config_arb;

    localparam int NP  = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TO  = 4;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } rd_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req_valid;
    logic [NP-1:0]     req_ready;
    logic [NP-1:0]     req_we;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*DW-1:0]  req_wdata;
    logic [NP*SW-1:0]  req_wstrb;
    logic [NP-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              rd;
    logic [AW-1:0]     raddr;
    logic [DW-1:0]     rdata;
    logic              rvalid;
    logic              wr;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [SW-1:0]     wstrb;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    rsp_t exp_rsp [$];
    wr_t  exp_wr  [$];
    rd_t  exp_rd  [$];

    logic [31:0] p_addr [NP] = '{32'h0000_0040, 32'h0000_0044};
    logic [31:0] p_data [NP] = '{32'h0000_0A0A, 32'h0000_0B0B};
    logic [3:0]  p_strb [NP] = '{4'h3, 4'hC};

    axi_config_arb #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rd        (rd),
        .raddr     (raddr),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .wr        (wr),
        .waddr     (waddr),
        .wdata     (wdata),
        .wstrb     (wstrb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] v;
        v = 2'b01;
        return v << p;
    endfunction

    // Monitor: every strobe or response the DUT presents must match the
    // oldest expectation, including the cycle it appears in.
    rsp_t m_rsp;
    wr_t  m_wr;
    rd_t  m_rd;
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid != '0) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    m_rsp = exp_rsp.pop_front();
                    chk("rsp_port",  64'(rsp_valid), 64'(onehot(m_rsp.port)));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rsp.rdata));
                    chk("rsp_err",   64'(rsp_err),   64'(m_rsp.err));
                    chk("rsp_cycle", 64'(cyc),       64'(m_rsp.cyc));
                end
            end
            if (wr) begin
                chk("wr_rd_excl", 64'(rd), 64'd0);
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 64'(wr), 64'd0);
                end else begin
                    m_wr = exp_wr.pop_front();
                    chk("waddr",    64'(waddr), 64'(m_wr.addr));
                    chk("wdata",    64'(wdata), 64'(m_wr.data));
                    chk("wstrb",    64'(wstrb), 64'(m_wr.strb));
                    chk("wr_cycle", 64'(cyc),   64'(m_wr.cyc));
                end
            end
            if (rd) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 64'(rd), 64'd0);
                end else begin
                    m_rd = exp_rd.pop_front();
                    chk("raddr",    64'(raddr), 64'(m_rd.addr));
                    chk("rd_cycle", 64'(cyc),   64'(m_rd.cyc));
                end
            end
        end
    end

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int w = 0; w < 40 && !done; w++) begin
            @(negedge clk);
            #1;
            if (exp_rsp.size() == 0 && exp_wr.size() == 0 && exp_rd.size() == 0)
                done = 1'b1;
        end
        if (!done) begin
            chk("drain_timeout", 64'd0, 64'd1);
            exp_rsp.delete();
            exp_wr.delete();
            exp_rd.delete();
        end
    endtask

    task automatic drive_port(input int p, input bit we, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb);
        req_we[p]               = we;
        req_addr[p*AW +: AW]    = addr;
        req_wdata[p*DW +: DW]   = data;
        req_wstrb[p*SW +: SW]   = strb;
        req_valid[p]            = 1'b1;
    endtask

    // Single transaction. k >= 0: rvalid arrives k cycles after the rd cycle;
    // k < 0: target stays silent and the timeout must answer.
    task automatic do_txn(input int p, input bit we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input int k, input logic [31:0] rdat);
        int   t;
        bit   got;
        rsp_t er;
        wr_t  ew;
        rd_t  eo;
        @(posedge clk);
        #1;
        drive_port(p, we, addr, data, strb);
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1'b1;
        end
        if (!got) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_valid[p] = 1'b0;
            return;
        end
        t = cyc;
        chk("req_ready", 64'(req_ready), 64'(onehot(p)));
        er.port  = p;
        er.rdata = (we || k < 0) ? 32'h0 : rdat;
        er.err   = !we && (k < 0);
        er.cyc   = we ? t + 2 : ((k >= 0) ? t + 2 + k : t + 2 + TO);
        exp_rsp.push_back(er);
        if (we) begin
            ew.addr = addr; ew.data = data; ew.strb = strb; ew.cyc = t + 1;
            exp_wr.push_back(ew);
        end else begin
            eo.addr = addr; eo.cyc = t + 1;
            exp_rd.push_back(eo);
        end
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
        if (!we && k >= 0) begin
            repeat (k) begin
                @(posedge clk);
                #1;
            end
            rvalid = 1'b1;
            rdata  = rdat;
            @(posedge clk);
            #1;
            rvalid = 1'b0;
        end
        wait_drain();
    endtask

    // Both ports hold writes; grants must alternate starting at 'first',
    // one accept every three cycles.
    task automatic run_both(input int n, input int first);
        int   exp_p;
        int   t;
        int   t_prev;
        bit   got;
        rsp_t er;
        wr_t  ew;
        exp_p  = first;
        t_prev = -1;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) drive_port(p, 1'b1, p_addr[p], p_data[p], p_strb[p]);
        for (int a = 0; a < n; a++) begin
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                @(negedge clk);
                if (req_ready != '0) got = 1'b1;
            end
            if (!got) begin
                chk("rr_accept_timeout", 64'd0, 64'd1);
                break;
            end
            t = cyc;
            chk("rr_grant", 64'(req_ready), 64'(onehot(exp_p)));
            if (t_prev >= 0) chk("rr_interval", 64'(t - t_prev), 64'd3);
            er.port = exp_p; er.rdata = 32'h0; er.err = 1'b0; er.cyc = t + 2;
            exp_rsp.push_back(er);
            ew.addr = p_addr[exp_p]; ew.data = p_data[exp_p];
            ew.strb = p_strb[exp_p]; ew.cyc  = t + 1;
            exp_wr.push_back(ew);
            t_prev = t;
            exp_p  = (exp_p + 1) % NP;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_drain();
    endtask

    // rvalid while idle must not produce a response.
    task automatic stray_rvalid(input logic [31:0] d);
        @(posedge clk);
        #1;
        rvalid = 1'b1;
        rdata  = d;
        @(posedge clk);
        #1;
        rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_no_rsp", 64'(rsp_valid), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  t;
        bit  got;
        rd_t eo;

        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rdata     = '0;
        rvalid    = 1'b0;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd",        64'(rd),        64'd0);
        chk("rst_wr",        64'(wr),        64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err",   64'(rsp_err),   64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_raddr",     64'(raddr),     64'd0);
        chk("rst_waddr",     64'(waddr),     64'd0);
        chk("rst_wdata",     64'(wdata),     64'd0);
        chk("rst_wstrb",     64'(wstrb),     64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write from port 0.
        do_txn(0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 0, 32'h0);
        // Read from port 1, data in the rd cycle.
        do_txn(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 32'h1234_5678);
        // Round-robin under continuous load: 0,1,0,1.
        run_both(4, 0);
        // Silent target: timeout response, then a late rvalid is ignored.
        do_txn(0, 1'b0, 32'h0000_0030, 32'h0, 4'h0, -1, 32'h0);
        stray_rvalid(32'hDEAD_BEEF);
        // Stray rvalid in idle, then a read with rvalid two cycles late.
        stray_rvalid(32'hFFFF_FFFF);
        do_txn(1, 1'b0, 32'h0000_0050, 32'h0, 4'h0, 2, 32'hCAFE_F00D);

        // Reset while waiting for read data (port 0 wins after port 1).
        @(posedge clk);
        #1;
        drive_port(0, 1'b0, 32'h0000_0060, 32'h0, 4'h0);
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1'b1;
        end
        if (!got) chk("rwait_accept_timeout", 64'd0, 64'd1);
        t = cyc;
        chk("rwait_req_ready", 64'(req_ready), 64'(onehot(0)));
        eo.addr = 32'h0000_0060;
        eo.cyc  = t + 1;
        exp_rd.push_back(eo);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("midrst_rd",        64'(rd),        64'd0);
        chk("midrst_wr",        64'(wr),        64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_raddr",     64'(raddr),     64'd0);
        chk("midrst_rsp_err",   64'(rsp_err),   64'd0);
        chk("midrst_rd_seen",   64'(exp_rd.size()), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // After reset port 0 must be granted first again.
        run_both(2, 0);

        wait_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
